// File: rtl/sdram_client_port.sv
// SDRAM client port: arbitrates one burst/write client against display scanout, which takes the backend only from IDLE.
// Optional macro SDRAM_CLIENT_PORT_FRAME_WRAP_EN makes burst addresses wrap at FRAME_WORDS.
module sdram_client_port #(
  parameter int READ_BURST_LENGTH = 8,
  parameter int FRAME_WORDS       = 96000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [1:0]  i_Command,
  input  logic [21:0] i_Data_Address,
  input  logic [31:0] i_Data_Write,
  output logic [31:0] o_Data_Read,
  output logic        o_Data_Read_Valid,
  output logic        o_Data_Write_Done,
  output logic        o_SDRAM_Requested,
  input  logic        i_SDRAM_Yield,
  input  logic        i_Display_Req,
  output logic        o_Display_Grant,
  output logic        o_Mem_Rd,
  output logic        o_Mem_Wr,
  output logic [21:0] o_Mem_Addr,
  output logic [31:0] o_Mem_Wdata,
  input  logic        i_Mem_Ready,
  input  logic        i_Mem_Rvalid,
  input  logic [31:0] i_Mem_Rdata
);

  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [7:0] BURST     = 8'(READ_BURST_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_DRAIN, S_WR_ISSUE, S_WR_DONE, S_DISPLAY
  } state_t;

  state_t      state;
  logic [7:0]  issue_cnt;
  logic [7:0]  ret_cnt;
  logic [21:0] next_addr;
  logic        ret_hit;
  logic        ret_last;

`ifdef SDRAM_CLIENT_PORT_FRAME_WRAP_EN
  localparam logic [21:0] ADDR_LAST = 22'(FRAME_WORDS - 1);
  always_comb begin
    next_addr = (o_Mem_Addr == ADDR_LAST) ? 22'd0 : o_Mem_Addr + 22'd1;
  end
`else
  always_comb begin
    next_addr = o_Mem_Addr + 22'd1;
  end
`endif

  // Returns only count while a burst is open with words still owed.
  always_comb begin
    ret_hit  = ((state == S_RD_ISSUE) || (state == S_RD_DRAIN)) && i_Mem_Rvalid && (ret_cnt != 8'd0);
    ret_last = ret_hit && (ret_cnt == 8'd1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state             <= S_IDLE;
      issue_cnt         <= 8'd0;
      ret_cnt           <= 8'd0;
      o_Data_Read       <= 32'd0;
      o_Data_Read_Valid <= 1'b0;
      o_Data_Write_Done <= 1'b0;
      o_SDRAM_Requested <= 1'b0;
      o_Display_Grant   <= 1'b0;
      o_Mem_Rd          <= 1'b0;
      o_Mem_Wr          <= 1'b0;
      o_Mem_Addr        <= 22'd0;
      o_Mem_Wdata       <= 32'd0;
    end else begin
      o_Data_Read_Valid <= 1'b0;
      o_Data_Write_Done <= 1'b0;

      if (ret_hit) begin
        o_Data_Read       <= i_Mem_Rdata;
        o_Data_Read_Valid <= 1'b1;
        ret_cnt           <= ret_cnt - 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (i_Display_Req) begin
            if (i_SDRAM_Yield) begin
              state             <= S_DISPLAY;
              o_Display_Grant   <= 1'b1;
              o_SDRAM_Requested <= 1'b0;
            end else begin
              o_SDRAM_Requested <= 1'b1;
            end
          end else if (o_SDRAM_Requested) begin
            o_SDRAM_Requested <= 1'b0;
          end else if (!o_Data_Read_Valid) begin
            // Holding off while the last read word is on the bus keeps a new burst from overlapping it.
            if (i_Command == CMD_READ) begin
              o_Mem_Addr <= i_Data_Address;
              issue_cnt  <= BURST;
              ret_cnt    <= BURST;
              o_Mem_Rd   <= 1'b1;
              state      <= S_RD_ISSUE;
            end else if (i_Command == CMD_WRITE) begin
              o_Mem_Addr  <= i_Data_Address;
              o_Mem_Wdata <= i_Data_Write;
              o_Mem_Wr    <= 1'b1;
              state       <= S_WR_ISSUE;
            end
          end
        end

        S_RD_ISSUE: begin
          if (i_Mem_Ready) begin
            o_Mem_Addr <= next_addr;
            issue_cnt  <= issue_cnt - 8'd1;
            if (issue_cnt == 8'd1) begin
              o_Mem_Rd <= 1'b0;
              state    <= S_RD_DRAIN;
            end
          end
        end

        S_RD_DRAIN: begin
          if ((ret_cnt == 8'd0) || ret_last) begin
            state <= S_IDLE;
          end
        end

        S_WR_ISSUE: begin
          if (i_Mem_Ready) begin
            o_Mem_Wr          <= 1'b0;
            o_Data_Write_Done <= 1'b1;
            state             <= S_WR_DONE;
          end
        end

        S_WR_DONE: begin
          state <= S_IDLE;
        end

        S_DISPLAY: begin
          if (!i_Display_Req) begin
            o_Display_Grant <= 1'b0;
            state           <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_client_port.sv
// Scoreboard bench for sdram_client_port: a backend model answers reads with a fixed address-derived pattern,
// and a negedge monitor pops expected addresses/data whenever the DUT issues requests or returns words.
module tb_sdram_client_port;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cmd;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] data_read;
  logic        data_read_valid;
  logic        write_done;
  logic        sdram_requested;
  logic        yield;
  logic        disp_req;
  logic        disp_grant;
  logic        mem_rd;
  logic        mem_wr;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  sdram_client_port #(.READ_BURST_LENGTH(8), .FRAME_WORDS(96000)) dut (
    .i_Clk             (clk),
    .i_Rst_n           (rst_n),
    .i_Command         (cmd),
    .i_Data_Address    (addr),
    .i_Data_Write      (wdata),
    .o_Data_Read       (data_read),
    .o_Data_Read_Valid (data_read_valid),
    .o_Data_Write_Done (write_done),
    .o_SDRAM_Requested (sdram_requested),
    .i_SDRAM_Yield     (yield),
    .i_Display_Req     (disp_req),
    .o_Display_Grant   (disp_grant),
    .o_Mem_Rd          (mem_rd),
    .o_Mem_Wr          (mem_wr),
    .o_Mem_Addr        (mem_addr),
    .o_Mem_Wdata       (mem_wdata),
    .i_Mem_Ready       (mem_ready),
    .i_Mem_Rvalid      (mem_rvalid),
    .i_Mem_Rdata       (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 2;
  int ready_delay = 0;
  int wait_cnt = 0;
  int rd_seen = 0;
  int done_seen = 0;
  int wr_cycles = 0;

  logic [21:0] exp_addr[$];
  logic [31:0] exp_rd[$];
  logic [21:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic [31:0] pipe_data[$];
  int          pipe_due[$];

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return {10'h2B5, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an output with no expectation queued, expected none", name);
  endtask

  always @(posedge clk) cyc++;

  // Monitor and backend model, both acting away from the active edge.
  always @(negedge clk) begin
    if (data_read_valid) begin
      rd_seen++;
      if (exp_rd.size() == 0) chk_unexpected("rd_data");
      else chk("rd_data", data_read, exp_rd.pop_front());
    end
    if (write_done) done_seen++;
    if (disp_grant) chk("grant_no_mem_req", {mem_rd, mem_wr}, 2'b00);
    if (mem_wr) wr_cycles++;

    if (pipe_due.size() > 0 && pipe_due[0] == cyc + 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pipe_data.pop_front();
      void'(pipe_due.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end

    if (mem_rd || mem_wr) begin
      if (wait_cnt < ready_delay) begin
        mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end

    if (mem_ready && mem_rd) begin
      if (exp_addr.size() == 0) chk_unexpected("rd_addr");
      else chk("rd_addr", mem_addr, exp_addr.pop_front());
      pipe_data.push_back(mem_word(mem_addr));
      pipe_due.push_back(cyc + 1 + lat);
    end
    if (mem_ready && mem_wr) begin
      if (exp_wr_addr.size() == 0) chk_unexpected("wr_req");
      else begin
        chk("wr_addr", mem_addr, exp_wr_addr.pop_front());
        chk("wr_data", mem_wdata, exp_wr_data.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [21:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd   = c;
    addr  = a;
    wdata = d;
    @(negedge clk);
    cmd = CMD_IDLE;
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget && rd_seen < n; i++) @(negedge clk);
    chk("rd_count", rd_seen >= n, 1'b1);
  endtask

  task automatic expect_burst(input logic [21:0] a0);
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(a0 + 22'(i));
      exp_rd.push_back(mem_word(a0 + 22'(i)));
    end
  endtask

  int rd_at_reset;
  logic [21:0] wrap_list[8];

  initial begin
    rst_n = 1'b1; cmd = CMD_IDLE; addr = '0; wdata = '0;
    yield = 1'b0; disp_req = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {data_read, data_read_valid, write_done, sdram_requested, disp_grant,
                          mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
    #19 rst_n = 1'b1;

    // Plain 8-word read at 0x10, ready always high, returns two cycles after acceptance.
    rd_seen = 0;
    expect_burst(22'h000010);
    issue(CMD_READ, 22'h000010, 32'h0);
    wait_rd(8, 100);
    repeat (2) @(negedge clk);
    chk("rd_done_idle_rd", mem_rd, 1'b0);
    chk("rd_final_count", rd_seen, 8);

    // Write with ready held off three cycles.
    ready_delay = 3;
    wr_cycles = 0;
    exp_wr_addr.push_back(22'h000100);
    exp_wr_data.push_back(32'hDEADBEEF);
    issue(CMD_WRITE, 22'h000100, 32'hDEADBEEF);
    for (int i = 0; i < 50 && done_seen < 1; i++) @(negedge clk);
    chk("wr_done_seen", done_seen, 1);
    chk("wr_cycles", wr_cycles, 4);
    repeat (3) @(negedge clk);
    chk("wr_done_once", done_seen, 1);
    chk("wr_released", mem_wr, 1'b0);
    ready_delay = 0;

    // Frame-end burst address.
`ifdef SDRAM_CLIENT_PORT_FRAME_WRAP_EN
    wrap_list = '{22'd95996, 22'd95997, 22'd95998, 22'd95999, 22'd0, 22'd1, 22'd2, 22'd3};
`else
    wrap_list = '{22'd95996, 22'd95997, 22'd95998, 22'd95999, 22'd96000, 22'd96001, 22'd96002, 22'd96003};
`endif
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(wrap_list[i]);
      exp_rd.push_back(mem_word(wrap_list[i]));
    end
    rd_seen = 0;
    issue(CMD_READ, 22'd95996, 32'h0);
    wait_rd(8, 100);
    repeat (2) @(negedge clk);

    // Top of the 22-bit address space rolls over to zero.
    wrap_list = '{22'h3FFFFE, 22'h3FFFFF, 22'h0, 22'h1, 22'h2, 22'h3, 22'h4, 22'h5};
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(wrap_list[i]);
      exp_rd.push_back(mem_word(wrap_list[i]));
    end
    rd_seen = 0;
    issue(CMD_READ, 22'h3FFFFE, 32'h0);
    wait_rd(8, 100);
    repeat (2) @(negedge clk);

    // Display request mid-burst waits for the burst, then for yield.
    rd_seen = 0;
    expect_burst(22'h000200);
    issue(CMD_READ, 22'h000200, 32'h0);
    wait_rd(2, 100);
    disp_req = 1'b1;
    wait_rd(5, 100);
    chk("disp_mid_burst_grant", disp_grant, 1'b0);
    chk("disp_mid_burst_req", sdram_requested, 1'b0);
    wait_rd(8, 100);
    repeat (3) @(negedge clk);
    chk("disp_requested", sdram_requested, 1'b1);
    chk("disp_not_granted", disp_grant, 1'b0);
    cmd = CMD_WRITE; addr = 22'h000123; wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    cmd = CMD_IDLE;
    chk("disp_cmd_blocked", mem_wr, 1'b0);
    yield = 1'b1;
    @(negedge clk);
    yield = 1'b0;
    chk("disp_granted", disp_grant, 1'b1);
    chk("disp_req_cleared", sdram_requested, 1'b0);
    cmd = CMD_READ; addr = 22'h000050;
    repeat (2) @(negedge clk);
    cmd = CMD_IDLE;
    chk("disp_no_rd", mem_rd, 1'b0);
    chk("disp_still_granted", disp_grant, 1'b1);
    disp_req = 1'b0;
    @(negedge clk);
    chk("disp_released", disp_grant, 1'b0);
    repeat (2) @(negedge clk);

    // Display request and read in the same IDLE cycle: display wins.
    disp_req = 1'b1; cmd = CMD_READ; addr = 22'h000300;
    @(negedge clk);
    cmd = CMD_IDLE;
    chk("tie_requested", sdram_requested, 1'b1);
    chk("tie_no_rd", mem_rd, 1'b0);
    @(negedge clk);
    chk("tie_no_rd_later", mem_rd, 1'b0);
    yield = 1'b1;
    @(negedge clk);
    yield = 1'b0;
    chk("tie_granted", disp_grant, 1'b1);
    disp_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("tie_released", disp_grant, 1'b0);

    // Reset in the middle of a burst; late returns must be dropped.
    lat = 4;
    rd_seen = 0;
    expect_burst(22'h000400);
    issue(CMD_READ, 22'h000400, 32'h0);
    wait_rd(3, 100);
    #2;
    rd_at_reset = rd_seen;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {data_read, data_read_valid, write_done, sdram_requested, disp_grant,
                           mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
    exp_rd.delete();
    exp_addr.delete();
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_late_valid", rd_seen, rd_at_reset);
    chk("midrst_partial", rd_at_reset < 8, 1'b1);

    // Port recovers after reset.
    lat = 1;
    rd_seen = 0;
    expect_burst(22'h000020);
    issue(CMD_READ, 22'h000020, 32'h0);
    wait_rd(8, 100);
    repeat (3) @(negedge clk);

    chk("left_rd_exp", exp_rd.size(), 0);
    chk("left_addr_exp", exp_addr.size(), 0);
    chk("left_wr_exp", exp_wr_addr.size(), 0);
    chk("total_write_done", done_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_client_port.md
SDRAM_CLIENT_PORT -- requirements
Module: sdram_client_port

Interface
REQ-001 Parameter READ_BURST_LENGTH, default 8, words returned per CMD_READ (1..255).
REQ-002 Parameter FRAME_WORDS, default 96000 (480*200), framebuffer size in 32-bit words.
REQ-003 i_Clk  input  1  single clock for all logic.
REQ-004 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_Command  input  2  client command from sdram.vh: CMD_IDLE=0, CMD_READ=1, CMD_WRITE=2; 3 treated as idle.
REQ-006 i_Data_Address  input  22  client word address, sampled at command acceptance.
REQ-007 i_Data_Write  input  32  client write data, sampled with CMD_WRITE.
REQ-008 o_Data_Read  output  32  read data word, registered.
REQ-009 o_Data_Read_Valid  output  1  one-cycle strobe per returned read word.
REQ-010 o_Data_Write_Done  output  1  one-cycle strobe on write completion.
REQ-011 o_SDRAM_Requested  output  1  asks the client to release the memory.
REQ-012 i_SDRAM_Yield  input  1  client confirms it is idle and released.
REQ-013 i_Display_Req  input  1  display scanout needs memory; held until done.
REQ-014 o_Display_Grant  output  1  display owns the memory backend.
REQ-015 o_Mem_Rd / o_Mem_Wr  output  1 each  backend read/write request, held until i_Mem_Ready.
REQ-016 o_Mem_Addr  output  22  backend word address.
REQ-017 o_Mem_Wdata  output  32  backend write data.
REQ-018 i_Mem_Ready  input  1  backend accepts current request this cycle.
REQ-019 i_Mem_Rvalid / i_Mem_Rdata  input  1 / 32  backend read return, in order, arbitrary latency.

Function
REQ-020 States: IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, WR_DONE, DISPLAY.
REQ-021 IDLE, i_Display_Req=1: assert o_SDRAM_Requested; move to DISPLAY only in a cycle with i_SDRAM_Yield=1; client commands are not accepted while o_SDRAM_Requested=1.
REQ-022 IDLE, no display request, i_Command=CMD_READ: latch address, load issue and return counters with READ_BURST_LENGTH, go RD_ISSUE.
REQ-023 RD_ISSUE: o_Mem_Rd=1; each cycle with i_Mem_Ready=1 advances o_Mem_Addr by one and decrements issue counter; at zero go RD_DRAIN.
REQ-024 Every i_Mem_Rvalid: o_Data_Read<=i_Mem_Rdata, o_Data_Read_Valid=1 next cycle (latency 1), return counter decrements; rvalid may arrive during RD_ISSUE.
REQ-025 When returned count reaches READ_BURST_LENGTH, return to IDLE; a new command is accepted no earlier than the cycle after the last o_Data_Read_Valid.
REQ-026 IDLE, i_Command=CMD_WRITE: latch address/data, go WR_ISSUE; o_Mem_Wr=1 until i_Mem_Ready; then WR_DONE pulses o_Data_Write_Done one cycle, back to IDLE; the WR_DONE cycle ignores i_Command.
REQ-027 Display priority applies only at IDLE; bursts and writes are never interrupted; o_SDRAM_Requested stays high from request until grant.
REQ-028 DISPLAY: o_Display_Grant=1, o_Mem_Rd=o_Mem_Wr=0; leave to IDLE the cycle after i_Display_Req=0; o_SDRAM_Requested cleared on entry.
REQ-029 Simultaneous i_Display_Req and client command in IDLE: display wins.
REQ-030 i_Mem_Rvalid outside a read with zero outstanding words is ignored.

Reset
REQ-031 Asynchronous on i_Rst_n low: state IDLE, all counters 0, o_Data_Read=0, o_Mem_Addr=0, o_Mem_Wdata=0, every 1-bit output 0.
REQ-032 Reset mid-burst abandons outstanding words; returns after release produce no o_Data_Read_Valid.

Configuration
REQ-033 Macro SDRAM_CLIENT_PORT_FRAME_WRAP_EN defined: burst address after FRAME_WORDS-1 becomes 0.
REQ-034 Macro undefined: burst address increments modulo 2^22; FRAME_WORDS unused.

Verification
REQ-035 Read at 0x000010, ready always 1, rvalid 2 cycles later -> 8 valids, data from 0x10..0x17, then IDLE.
REQ-036 Write 0xDEADBEEF to 0x000100, i_Mem_Ready delayed 3 cycles -> o_Mem_Wr 4 cycles, one o_Data_Write_Done.
REQ-037 i_Display_Req during read burst -> grant only after burst end and i_SDRAM_Yield=1; no backend requests while granted.
REQ-038 With macro defined, read at 95996 -> addresses 95996..95999, 0..3.
REQ-039 i_Rst_n low after 3 of 8 valids -> outputs 0 immediately; late rvalids produce no valid.
REQ-040 Display request and CMD_READ in the same IDLE cycle -> o_SDRAM_Requested=1, read not started.
